// File: rtl/io_reg_file_x_if.sv
// io_reg_file_x_if: I/O bus between the core decoder and the internal register file.
interface io_reg_file_x_if;
  logic [5:0] adr;
  logic       we;
  logic       re;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] e_data;
  modport master (output adr, we, re, wdata, e_data, input rdata);
  modport slave  (input adr, we, re, wdata, e_data, output rdata);
endinterface

// File: rtl/io_reg_file_x.sv
// io_reg_file_x: AVR internal I/O registers (SREG, SP, RAMPx/EIND, CCP) with SPL-write IRQ lock.
module io_reg_file_x #(
  parameter int SP_W         = 16,
  parameter int SP_RST       = 0,
  parameter int RAMP_W       = 8,
  parameter bit ENA_RAMPZ    = 0,
  parameter bit ENA_RAMPXYD  = 0,
  parameter bit ENA_EIND     = 0,
  parameter bit ENA_CCP      = 0,
  parameter int CCP_WIN      = 4,
  parameter int IRQ_LOCK_CYC = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ena_i,
  io_reg_file_x_if.slave  bus,
  input  logic [7:0]      sreg_i,
  input  logic [7:0]      sreg_we_i,
  output logic [7:0]      sreg_o,
  output logic [SP_W-1:0] sp_o,
  input  logic            sp_we_i,
  input  logic            sp_pop_i,
  input  logic            rampz_inc_i,
  output logic [7:0]      rampd_o,
  output logic [7:0]      rampx_o,
  output logic [7:0]      rampy_o,
  output logic [7:0]      rampz_o,
  output logic [7:0]      eind_o,
  output logic            irq_lock_o,
  output logic            ccp_io_o,
  output logic            ccp_spm_o
);
  logic [RAMP_W-1:0] rampd, rampx, rampy, rampz, eind, wd_ramp;
  logic [3:0] lock_cnt, io_cnt, spm_cnt;
  logic [SP_W-1:0] sp_d;
  logic [7:0] sreg_d;
  logic wr_sreg, wr_sph, wr_spl, wr_eind, wr_rampz, wr_rampy, wr_rampx, wr_rampd, wr_ccp;
  assign wr_sreg  = bus.we && bus.adr == 6'h3F;
  assign wr_sph   = (SP_W > 8) && bus.we && bus.adr == 6'h3E;
  assign wr_spl   = bus.we && bus.adr == 6'h3D;
  assign wr_eind  = ENA_EIND && bus.we && bus.adr == 6'h3C;
  assign wr_rampz = ENA_RAMPZ && bus.we && bus.adr == 6'h3B;
  assign wr_rampy = ENA_RAMPXYD && bus.we && bus.adr == 6'h3A;
  assign wr_rampx = ENA_RAMPXYD && bus.we && bus.adr == 6'h39;
  assign wr_rampd = ENA_RAMPXYD && bus.we && bus.adr == 6'h38;
  assign wr_ccp   = ENA_CCP && bus.we && bus.adr == 6'h34;
  assign wd_ramp  = bus.wdata[RAMP_W-1:0];
  assign sreg_d = wr_sreg ? bus.wdata : (sreg_o & ~sreg_we_i) | (sreg_i & sreg_we_i);
  // A bus write to either SP byte drops any concurrent push/pop entirely
  assign sp_d = wr_spl  ? (sp_o & ~SP_W'(8'hFF)) | SP_W'(bus.wdata)
              : wr_sph  ? (sp_o & SP_W'(8'hFF)) | SP_W'({bus.wdata, 8'h00})
              : sp_we_i ? (sp_pop_i ? sp_o + SP_W'(1) : sp_o - SP_W'(1))
              : sp_o;
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      sreg_o   <= '0;
      sp_o     <= SP_W'(SP_RST);
      rampd    <= '0;
      rampx    <= '0;
      rampy    <= '0;
      rampz    <= '0;
      eind     <= '0;
      lock_cnt <= '0;
      io_cnt   <= '0;
      spm_cnt  <= '0;
    end else if (ena_i) begin
      sreg_o   <= sreg_d;
      sp_o     <= sp_d;
      rampd    <= wr_rampd ? wd_ramp : rampd;
      rampx    <= wr_rampx ? wd_ramp : rampx;
      rampy    <= wr_rampy ? wd_ramp : rampy;
      eind     <= wr_eind ? wd_ramp : eind;
      rampz    <= wr_rampz ? wd_ramp : rampz + RAMP_W'(ENA_RAMPZ && rampz_inc_i);
      lock_cnt <= wr_spl ? 4'(IRQ_LOCK_CYC) : wr_sph ? 4'd0 : lock_cnt - 4'(lock_cnt != 4'd0);
      io_cnt   <= wr_ccp && bus.wdata == 8'hD8 ? 4'(CCP_WIN) : io_cnt - 4'(io_cnt != 4'd0);
      spm_cnt  <= wr_ccp && bus.wdata == 8'h9D ? 4'(CCP_WIN) : spm_cnt - 4'(spm_cnt != 4'd0);
    end
  assign rampd_o    = 8'(rampd);
  assign rampx_o    = 8'(rampx);
  assign rampy_o    = 8'(rampy);
  assign rampz_o    = 8'(rampz);
  assign eind_o     = 8'(eind);
  assign irq_lock_o = lock_cnt != 4'd0;
  assign ccp_io_o   = io_cnt != 4'd0;
  assign ccp_spm_o  = spm_cnt != 4'd0;
  // Absent registers fall through to the external data path
  always_comb begin
    bus.rdata = bus.e_data;
    if (bus.re)
      case (bus.adr)
        6'h3F: bus.rdata = sreg_o;
        6'h3E: if (SP_W > 8) bus.rdata = 8'(sp_o >> 8);
        6'h3D: bus.rdata = sp_o[7:0];
        6'h3C: if (ENA_EIND) bus.rdata = eind_o;
        6'h3B: if (ENA_RAMPZ) bus.rdata = rampz_o;
        6'h3A: if (ENA_RAMPXYD) bus.rdata = rampy_o;
        6'h39: if (ENA_RAMPXYD) bus.rdata = rampx_o;
        6'h38: if (ENA_RAMPXYD) bus.rdata = rampd_o;
        6'h34: if (ENA_CCP) bus.rdata = {6'b0, ccp_spm_o, ccp_io_o};
        default: ;
      endcase
  end
endmodule

// File: tb/tb_io_reg_file_x.sv
// tb_io_reg_file_x: directed vector table, hand sequences and randomized model comparison.
module tb_io_reg_file_x;
  logic clk = 1'b0;
  logic rst_n = 1'b0, ena = 1'b0;
  logic [7:0] sreg_i = '0, sreg_we = '0;
  logic sp_we = 1'b0, sp_pop = 1'b0, rinc = 1'b0;
  logic [7:0] sreg_o, rampd_o, rampx_o, rampy_o, rampz_o, eind_o;
  logic [11:0] sp_o;
  logic irq, cio, csp;
  logic [7:0] sreg2, rd2, rx2, ry2, rz2, ei2, sp2;
  logic irq2, cio2, csp2;
  int checks = 0, errors = 0;

  io_reg_file_x_if bus();
  io_reg_file_x_if bus2();
  assign bus2.adr    = bus.adr;
  assign bus2.we     = bus.we;
  assign bus2.re     = bus.re;
  assign bus2.wdata  = bus.wdata;
  assign bus2.e_data = bus.e_data;

  io_reg_file_x #(.SP_W(12), .SP_RST('h8FF), .RAMP_W(2), .ENA_RAMPZ(1), .ENA_RAMPXYD(1),
                  .ENA_EIND(1), .ENA_CCP(1), .CCP_WIN(4), .IRQ_LOCK_CYC(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .bus(bus), .sreg_i(sreg_i), .sreg_we_i(sreg_we),
    .sreg_o(sreg_o), .sp_o(sp_o), .sp_we_i(sp_we), .sp_pop_i(sp_pop), .rampz_inc_i(rinc),
    .rampd_o(rampd_o), .rampx_o(rampx_o), .rampy_o(rampy_o), .rampz_o(rampz_o), .eind_o(eind_o),
    .irq_lock_o(irq), .ccp_io_o(cio), .ccp_spm_o(csp));

  io_reg_file_x #(.SP_W(8)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .bus(bus2), .sreg_i(sreg_i), .sreg_we_i(sreg_we),
    .sreg_o(sreg2), .sp_o(sp2), .sp_we_i(sp_we), .sp_pop_i(sp_pop), .rampz_inc_i(rinc),
    .rampd_o(rd2), .rampx_o(rx2), .rampy_o(ry2), .rampz_o(rz2), .eind_o(ei2),
    .irq_lock_o(irq2), .ccp_io_o(cio2), .ccp_spm_o(csp2));

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, ena, we, re;
    logic [5:0] adr;
    logic [7:0] d, e, sv, sw;
    logic spw, pop, ri;
    logic [7:0] xdo;
    logic [11:0] xsp;
    logic [7:0] xsreg;
    logic [1:0] xrz;
    logic xlk, xcio, xcsp;
  } vec_t;
  vec_t tbl[$];

  logic [5:0] adrs [9] = '{6'h3F, 6'h3E, 6'h3D, 6'h3C, 6'h3B, 6'h3A, 6'h39, 6'h38, 6'h34};

  int m_sp, m_rz, m_ry, m_rx, m_rd, m_ei, m_cio, m_csp, m_lk;
  logic [7:0] m_sreg;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(input logic r, en, w, rd, input logic [5:0] a, input logic [7:0] d, e, sv, sw,
                     input logic spw, pop, ri, input logic [7:0] xdo, input logic [11:0] xsp,
                     input logic [7:0] xs, input logic [1:0] xrz, input logic xlk, xcio, xcsp);
    tbl.push_back('{r, en, w, rd, a, d, e, sv, sw, spw, pop, ri, xdo, xsp, xs, xrz, xlk, xcio, xcsp});
  endtask

  task automatic drive(input logic r, en, w, rd, input logic [5:0] a, input logic [7:0] d, e, sv, sw,
                       input logic spw, pop, ri);
    rst_n = r; ena = en; bus.we = w; bus.re = rd; bus.adr = a; bus.wdata = d; bus.e_data = e;
    sreg_i = sv; sreg_we = sw; sp_we = spw; sp_pop = pop; rinc = ri;
  endtask

  task automatic idle();
    drive(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  function automatic int mread(logic re_, logic [5:0] a, logic [7:0] e);
    if (!re_) return int'(e);
    case (a)
      6'h3F: return int'(m_sreg);
      6'h3E: return m_sp / 256;
      6'h3D: return m_sp % 256;
      6'h3C: return m_ei;
      6'h3B: return m_rz;
      6'h3A: return m_ry;
      6'h39: return m_rx;
      6'h38: return m_rd;
      6'h34: return (m_csp > 0 ? 2 : 0) + (m_cio > 0 ? 1 : 0);
      default: return int'(e);
    endcase
  endfunction

  task automatic mstep();
    int a, d;
    bit w;
    a = int'(bus.adr); d = int'(bus.wdata); w = bus.we;
    if (!rst_n) begin
      m_sreg = 0; m_sp = 'h8FF; m_rz = 0; m_ry = 0; m_rx = 0; m_rd = 0; m_ei = 0;
      m_cio = 0; m_csp = 0; m_lk = 0;
    end else if (ena) begin
      if (w && a == 'h3F) m_sreg = 8'(d);
      else for (int i = 0; i < 8; i++) if (sreg_we[i]) m_sreg[i] = sreg_i[i];
      if (w && a == 'h3D) m_sp = (m_sp / 256) * 256 + d;
      else if (w && a == 'h3E) m_sp = (d % 16) * 256 + m_sp % 256;
      else if (sp_we) m_sp = (m_sp + (sp_pop ? 1 : 4095)) % 4096;
      if (w && a == 'h3D) m_lk = 4;
      else if (w && a == 'h3E) m_lk = 0;
      else if (m_lk > 0) m_lk--;
      m_cio = (w && a == 'h34 && d == 'hD8) ? 4 : (m_cio > 0 ? m_cio - 1 : 0);
      m_csp = (w && a == 'h34 && d == 'h9D) ? 4 : (m_csp > 0 ? m_csp - 1 : 0);
      if (w && a == 'h3B) m_rz = d % 4;
      else if (rinc) m_rz = (m_rz + 1) % 4;
      if (w && a == 'h3A) m_ry = d % 4;
      if (w && a == 'h39) m_rx = d % 4;
      if (w && a == 'h38) m_rd = d % 4;
      if (w && a == 'h3C) m_ei = d % 4;
    end
  endtask

  initial begin
    vec_t v;
    logic [5:0] a;
    logic [7:0] d;
    bus.adr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0; bus.e_data = '0;
    //  r en w rd adr    d      e      sv     sw    spw pop ri | xdo   xsp     xsreg  rz lk io spm
    add(0, 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h8FF, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 1, 6'h3E, 8'h00, 8'h77, 8'h00, 8'h00, 0, 0, 0, 8'h08, 12'h8FF, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 0, 6'h3D, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h800, 8'h00, 0, 1, 0, 0);
    add(1, 1, 1, 0, 6'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 12'hFFF, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 8'h00, 12'h000, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 0, 6'h3E, 8'hF8, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h800, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 0, 6'h3D, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 12'h855, 8'h00, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h00, 0, 1, 0, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h00, 0, 0, 0, 0);
    add(1, 1, 1, 0, 6'h3F, 8'h80, 8'h00, 8'h01, 8'h01, 0, 0, 0, 8'h00, 12'h855, 8'h80, 0, 0, 0, 0);
    add(1, 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 12'h855, 8'h80, 0, 0, 0, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h01, 8'h03, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 0, 0);
    add(1, 1, 1, 0, 6'h34, 8'hD8, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 1, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 1, 0);
    add(1, 1, 0, 1, 6'h34, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h01, 12'h855, 8'h81, 0, 0, 1, 0);
    add(1, 1, 1, 0, 6'h34, 8'hD8, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 1, 0);
    add(1, 1, 1, 0, 6'h34, 8'h12, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++)
      add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 1, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 0, 0);
    add(1, 1, 1, 1, 6'h34, 8'h9D, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 0, 0, 0, 1);
    add(1, 1, 0, 1, 6'h34, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h02, 12'h855, 8'h81, 0, 0, 0, 1);
    add(1, 1, 1, 0, 6'h3B, 8'h03, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h855, 8'h81, 3, 0, 0, 1);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 12'h855, 8'h81, 0, 0, 0, 1);
    add(1, 1, 1, 0, 6'h3B, 8'h02, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 12'h855, 8'h81, 2, 0, 0, 0);
    add(1, 1, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h00, 12'h855, 8'h81, 3, 0, 0, 0);
    add(1, 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 8'h00, 12'h855, 8'h81, 3, 0, 0, 0);
    add(0, 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 12'h8FF, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 0, 6'h3F, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 8'hA5, 12'h8FF, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 1, 6'h20, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 0, 0, 8'h3C, 12'h8FF, 8'h00, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.rst_n, v.ena, v.we, v.re, v.adr, v.d, v.e, v.sv, v.sw, v.spw, v.pop, v.ri);
      #2;
      chk($sformatf("row%0d_rdata", i), bus.rdata, v.xdo);
      edge_();
      chk($sformatf("row%0d_sp", i), sp_o, v.xsp);
      chk($sformatf("row%0d_sreg", i), sreg_o, v.xsreg);
      chk($sformatf("row%0d_rampz", i), rampz_o, {6'b0, v.xrz});
      chk($sformatf("row%0d_lock", i), {irq, cio, csp}, {v.xlk, v.xcio, v.xcsp});
    end

    // SPL write then SPH write two cycles later; SP_W=8 instance has no SPH to clear its lock
    drive(1, 1, 1, 0, 6'h3D, 8'h10, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    edge_();
    chk("spl_lock", {irq, irq2}, 2'b11);
    chk("spl_sp", sp_o, 12'h810);
    chk("spl_sp8", sp2, 8'h10);
    idle();
    edge_();
    chk("lock_hold", {irq, irq2}, 2'b11);
    drive(1, 1, 1, 0, 6'h3E, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    edge_();
    chk("sph_clear", {irq, irq2}, 2'b01);
    chk("sph_sp", sp_o, 12'h110);
    chk("sph_sp8", sp2, 8'h10);
    drive(1, 1, 1, 1, 6'h3B, 8'h03, 8'hA5, 8'h00, 8'h00, 0, 0, 0);
    #2;
    chk("rampz_absent_rd", bus2.rdata, 8'hA5);
    chk("rampz_rd", bus.rdata, 8'h00);
    edge_();
    chk("rampz_absent_wr", rz2, 8'h00);
    chk("rampz_wr", rampz_o, 8'h03);
    drive(1, 1, 1, 1, 6'h39, 8'hFF, 8'h5A, 8'h00, 8'h00, 0, 0, 0);
    edge_();
    chk("rampx_zext", rampx_o, 8'h03);
    chk("rampx_absent_rd", bus2.rdata, 8'h5A);
    chk("rampx_rd", bus.rdata, 8'h03);
    drive(1, 1, 0, 1, 6'h3E, 8'h00, 8'h66, 8'h00, 8'h00, 0, 0, 0);
    #2;
    chk("sph_absent_rd", bus2.rdata, 8'h66);
    chk("sph_rd", bus.rdata, 8'h01);
    bus.adr = 6'h34;
    #1;
    chk("ccp_absent_rd", bus2.rdata, 8'h66);

    drive(0, 0, 0, 0, 6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    mstep();
    edge_();
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 4) == 0) ? 6'($urandom) : adrs[$urandom_range(0, 8)];
      d = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1 ? 8'hD8 : 8'h9D) : 8'($urandom);
      drive(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, d, 8'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      #2;
      chk("rnd_rdata", bus.rdata, mread(bus.re, bus.adr, bus.e_data));
      mstep();
      edge_();
      chk("rnd_sreg", sreg_o, m_sreg);
      chk("rnd_sp", sp_o, m_sp);
      chk("rnd_ramp", {rampd_o, rampx_o, rampy_o, rampz_o, eind_o},
          {8'(m_rd), 8'(m_rx), 8'(m_ry), 8'(m_rz), 8'(m_ei)});
      chk("rnd_flags", {irq, cio, csp}, {m_lk > 0, m_cio > 0, m_csp > 0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
